dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (port 0) and a
//  secondary loader/debug master (port 1). Fixed priority to port 0 with a starvation
//  guard for port 1. Tracks in-flight reads so each rdata returns to its owner.
//  Drives the pipeline stall when the MEM-stage access cannot complete this cycle.
// PARAMETERS
//  AW          9   data memory word-address width
//  DW          32  data width
//  RD_LAT      1   memory read latency in cycles, legal 1..3
//  STARVE_MAX  4   consecutive denied cycles for port 1 before a forced grant, >=1
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous active-low reset
//  p0_req      in   1   pipeline access request (load or store)
//  p0_wr       in   1   1 = store, 0 = load
//  p0_addr     in   AW  word address
//  p0_wdata    in   DW  store data
//  p0_funct3   in   3   access size/sign code, passed to memory unchanged
//  p0_gnt      out  1   access issued to memory this cycle
//  p0_rvalid   out  1   load data valid for port 0
//  p1_req/p1_wr/p1_addr/p1_wdata/p1_funct3  in  1/1/AW/DW/3  same as port 0
//  p1_gnt      out  1   access issued for port 1 this cycle
//  p1_rvalid   out  1   load data valid for port 1
//  rdata       out  DW  load data, qualified by p0_rvalid or p1_rvalid
//  pipe_stall  out  1   hold the pipeline (PC, IF/ID, ID/EX)
//  mem_wr      out  1   memory write enable
//  mem_addr    out  AW  memory address
//  mem_wdata   out  DW  memory write data
//  mem_funct3  out  3   memory access code
//  mem_rdata   in   DW  memory read data, valid RD_LAT cycles after issue
// BEHAVIOUR
//  - Clock is clk; reset is rst_n, asynchronous and active-low. While rst_n=0:
//    gnt, rvalid, mem_wr and pipe_stall are 0; rdata, mem_addr, mem_wdata, mem_funct3
//    are 0; starvation counter is 0; FSM is in NORMAL; the in-flight tag pipe is cleared.
//  - At most one access per cycle. Grant is combinational from req and state.
//    mem_* reflect the granted port's payload in the same cycle; memory samples at posedge.
//  - No grant: mem_wr=0. mem_addr/mem_wdata/mem_funct3 hold their last issued values.
//  - A requester holds req and its payload stable until it sees gnt. One beat per gnt.
//  - FSM NORMAL: p0_req wins. p1 is granted only when p0_req=0.
//  - Starvation counter (clog2(STARVE_MAX+1) bits, saturating):
//    - increments on each cycle with p1_req & ~p1_gnt;
//    - clears on p1_gnt or p1_req=0.
//    When it reaches STARVE_MAX, the FSM moves to FORCE at the next edge.
//  - FSM FORCE: lasts exactly one cycle. If p1_req=1, p1 is granted and p0 is denied.
//    Returns to NORMAL unconditionally; counter clears.
//  - Read tracking: each granted load pushes {valid, owner} into an RD_LAT-deep shift pipe.
//    On exit: rvalid of the owner = 1 and rdata = mem_rdata. Stores push valid=0.
//    No response is produced for stores.
//  - Responses are in issue order. A p1 read and a p0 read never return in the same cycle.
//  - pipe_stall = (p0_req & ~p0_gnt) | p0_wait.
//    p0_wait = 1 while a p0 load is in flight and its rvalid has not yet fired.
//    With RD_LAT=1 the cycle after the grant is not a stall; the pipeline takes rdata then.
//  - Simultaneous p0 and p1 requests with the counter at 0: p0 granted, p1 counter -> 1.
//  - Reset mid-read: the in-flight read is discarded and no rvalid follows reset release.
// TESTING
//  1. Reset: rst_n=0 asserted asynchronously mid-cycle -> all outputs 0 immediately.
//     After release, no rvalid appears for the 3 cycles following.
//  2. p0 load addr 9'h010, RD_LAT=1, memory returns 32'hDEADBEEF ->
//     p0_gnt=1 in cycle 0, p0_rvalid=1 with rdata=32'hDEADBEEF in cycle 1, pipe_stall=0.
//  3. p0_req held high continuously with p1_req=1 at cycle 0, STARVE_MAX=4 ->
//     p1_gnt=1 exactly in cycle 4 with pipe_stall=1 that cycle.
//     p0 is granted in cycles 0-3 and 5.
//  4. p1 store addr 9'h020 data 32'h12345678 with p0 idle -> mem_wr=1 same cycle.
//     A later p0 load of 9'h020 returns 32'h12345678.
//  5. RD_LAT=3: p1 load issued in cycle 0, p0 load in cycle 1 ->
//     p1_rvalid in cycle 3, p0_rvalid in cycle 4; pipe_stall=1 in cycles 2-3.
//  6. Both req=1 and the counter at 0 -> p0_gnt=1 and p1_gnt=0.
//     The p1 counter reaches STARVE_MAX only with no gap in p1_req.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (p0, priority) and a loader (p1),
// with a starvation guard for p1, and steers each read response back to its owner after RD_LAT cycles.
module dmem_arbiter #(
  parameter int AW         = 9,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_wr,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [2:0]    p0_funct3,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_wr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [2:0]    p1_funct3,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          pipe_stall,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_funct3,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RD_LAT-1:0] pipe_vld, pipe_own;  // own: 1 = p1
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    funct3_q;
  logic          issue_rd;
  logic          p0_wait;

  // Grants are gated by rst_n so every output is quiet the moment reset asserts.
  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    state_nxt = NORMAL;
    cnt_nxt   = '0;
    if (rst_n) begin
      if (state == FORCE && p1_req) p1_gnt = 1'b1;
      else if (p0_req)              p0_gnt = 1'b1;
      else                          p1_gnt = p1_req;
    end
    // Entering FORCE on the same edge the count hits the limit gives p1 its grant
    // in the cycle right after the STARVE_MAX-th denial.
    if (state == NORMAL && p1_req && !p1_gnt) begin
      cnt_nxt = (cnt == SMAX) ? cnt : cnt + CW'(1);
      if (cnt_nxt == SMAX) state_nxt = FORCE;
    end
  end

  always_comb begin
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_funct3 = funct3_q;
    mem_wr     = 1'b0;
    if (p1_gnt) begin
      mem_addr   = p1_addr;
      mem_wdata  = p1_wdata;
      mem_funct3 = p1_funct3;
      mem_wr     = p1_wr;
    end else if (p0_gnt) begin
      mem_addr   = p0_addr;
      mem_wdata  = p0_wdata;
      mem_funct3 = p0_funct3;
      mem_wr     = p0_wr;
    end
  end

  assign issue_rd = (p0_gnt & ~p0_wr) | (p1_gnt & ~p1_wr);

  // The last stage is the return cycle itself, so it does not count as waiting.
  always_comb begin
    p0_wait = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++)
      p0_wait = p0_wait | (pipe_vld[i] & ~pipe_own[i]);
  end

  assign p0_rvalid  = pipe_vld[RD_LAT-1] & ~pipe_own[RD_LAT-1];
  assign p1_rvalid  = pipe_vld[RD_LAT-1] & pipe_own[RD_LAT-1];
  assign rdata      = (p0_rvalid | p1_rvalid) ? mem_rdata : '0;
  assign pipe_stall = rst_n & ((p0_req & ~p0_gnt) | p0_wait);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      cnt      <= '0;
      pipe_vld <= '0;
      pipe_own <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pipe_vld[0] <= issue_rd;
      pipe_own[0] <= p1_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
      if (p0_gnt | p1_gnt) begin
        addr_q   <= mem_addr;
        wdata_q  <= mem_wdata;
        funct3_q <= mem_funct3;
      end
    end
  end

endmodule
